// File: rtl/dispatcher_bram_pkg.sv
// Shared types and default geometry for the ping-pong dispatcher staging memory.
package dispatcher_bram_pkg;

  typedef enum logic [1:0] {FREE, FILLING, UNPACKING, READY} bank_state_t;
  typedef enum logic {IDLE, RUN} unpack_state_t;

  localparam int DEF_MAN_WIDTH        = 256;
  localparam int DEF_EXP_WIDTH        = 8;
  localparam int DEF_NUM_GROUPS       = 512;
  localparam int DEF_EXP_PER_LINE     = DEF_MAN_WIDTH / DEF_EXP_WIDTH;
  localparam int DEF_EXP_PACKED_DEPTH = DEF_NUM_GROUPS / DEF_EXP_PER_LINE;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/dispatcher_bram_side.sv
// One operand side: NUM_BANKS ping-pong banks, the exponent unpacker and the read path.
module dispatcher_bram_side
  import dispatcher_bram_pkg::*;
#(
  parameter int NUM_BANKS        = 2,
  parameter int MAN_WIDTH        = 256,
  parameter int EXP_WIDTH        = 8,
  parameter int NUM_GROUPS       = 512,
  parameter int UNPACK_LANES     = 4,
  parameter int EXP_PER_LINE     = MAN_WIDTH / EXP_WIDTH,
  parameter int EXP_PACKED_DEPTH = NUM_GROUPS / EXP_PER_LINE,
  parameter int WR_ADDR_WIDTH    = $clog2(EXP_PACKED_DEPTH + NUM_GROUPS),
  parameter int RD_ADDR_WIDTH    = $clog2(NUM_GROUPS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     wr_en,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [MAN_WIDTH-1:0]     wr_data,
  input  logic                     commit,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic [MAN_WIDTH-1:0]     man_rd_data,
  output logic [EXP_WIDTH-1:0]     exp_rd_data,
  output logic                     rd_valid,
  output logic                     bank_ready,
  input  logic                     rel,
  output logic                     reject
);
  localparam int BANK_W     = $clog2(NUM_BANKS);
  localparam int STEPS      = NUM_GROUPS / UNPACK_LANES;
  localparam int STEP_W     = clog2_min1(STEPS);
  localparam int PK_W       = clog2_min1(EXP_PACKED_DEPTH);
  localparam int LANE_W     = clog2_min1(UNPACK_LANES);
  localparam int AL_WIDTH   = UNPACK_LANES * EXP_WIDTH;
  localparam int LINE_BIT_W = clog2_min1(MAN_WIDTH);
  localparam int AL_BIT_W   = clog2_min1(AL_WIDTH);

  logic [MAN_WIDTH-1:0] man_mem [NUM_BANKS][NUM_GROUPS];
  logic [MAN_WIDTH-1:0] pk_mem  [NUM_BANKS][EXP_PACKED_DEPTH];
  logic [AL_WIDTH-1:0]  al_mem  [NUM_BANKS][STEPS];

  bank_state_t          state_reg [NUM_BANKS];
  unpack_state_t        ustate_reg, ustate_next;
  logic [BANK_W-1:0]    fill_ptr_reg, rd_ptr_reg, ubank_reg;
  logic [STEP_W-1:0]    step_reg;
  logic [MAN_WIDTH-1:0] pk_line_reg, man_rd_reg;
  logic [AL_WIDTH-1:0]  al_rd_reg;
  logic [LANE_W-1:0]    lane_reg;
  logic                 rd_valid_reg;

  logic fill_open, wr_ok, commit_ok, rd_ok, rel_ok, last_step, wr_is_pk;
  logic [RD_ADDR_WIDTH-1:0] man_waddr;
  logic [BANK_W-1:0]        pk_bank;
  logic [PK_W-1:0]          pk_line;
  logic [STEP_W:0]          next_step;
  logic [AL_WIDTH-1:0]      al_word;
  logic [AL_BIT_W-1:0]      exp_sel;

  assign fill_open  = (state_reg[fill_ptr_reg] == FREE) || (state_reg[fill_ptr_reg] == FILLING);
  assign wr_ready   = fill_open && (ustate_reg == IDLE);
  assign bank_ready = (state_reg[rd_ptr_reg] == READY);
  assign wr_ok      = wr_en && wr_ready;
  assign commit_ok  = commit && wr_ready;
  assign rd_ok      = rd_en && bank_ready;
  assign rel_ok     = rel && bank_ready;
  assign last_step  = (ustate_reg == RUN) && (step_reg == STEP_W'(STEPS - 1));
  assign reject     = ((wr_en || commit) && !wr_ready) || ((rd_en || rel) && !bank_ready);
  assign wr_is_pk   = wr_addr < WR_ADDR_WIDTH'(EXP_PACKED_DEPTH);
  assign man_waddr  = RD_ADDR_WIDTH'(wr_addr - WR_ADDR_WIDTH'(EXP_PACKED_DEPTH));

  always_comb begin
    ustate_next = ustate_reg;
    case (ustate_reg)
      IDLE:    if (commit_ok) ustate_next = RUN;
      RUN:     if (last_step) ustate_next = IDLE;
      default: ustate_next = IDLE;
    endcase
  end

  // The packed line for the next step is fetched one cycle ahead; while idle the
  // fill bank's line 0 is kept prefetched so step 0 can start right after commit.
  always_comb begin
    pk_bank   = fill_ptr_reg;
    pk_line   = '0;
    next_step = {1'b0, step_reg} + 1'b1;
    if ((ustate_reg == RUN) && !last_step) begin
      pk_bank = ubank_reg;
      pk_line = PK_W'((32'(next_step) * UNPACK_LANES) / EXP_PER_LINE);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < UNPACK_LANES; gi++) begin : g_lane
      logic [31:0]           grp;
      logic [LINE_BIT_W-1:0] bit_idx;
      assign grp     = 32'(step_reg) * UNPACK_LANES + gi;
      assign bit_idx = LINE_BIT_W'(EXP_WIDTH * (grp % EXP_PER_LINE));
      assign al_word[gi*EXP_WIDTH +: EXP_WIDTH] = pk_line_reg[bit_idx +: EXP_WIDTH];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      if (wr_is_pk) pk_mem[fill_ptr_reg][PK_W'(wr_addr)] <= wr_data;
      else          man_mem[fill_ptr_reg][man_waddr]     <= wr_data;
    end
    if (ustate_reg == RUN) al_mem[ubank_reg][step_reg] <= al_word;
    // Forward a same-cycle write of line 0 so a write+commit pair unpacks the new data.
    pk_line_reg <= (wr_ok && (wr_addr == '0)) ? wr_data : pk_mem[pk_bank][pk_line];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int b = 0; b < NUM_BANKS; b++) state_reg[b] <= FREE;
      ustate_reg   <= IDLE;
      fill_ptr_reg <= '0;
      rd_ptr_reg   <= '0;
      ubank_reg    <= '0;
      step_reg     <= '0;
    end else begin
      ustate_reg <= ustate_next;
      if (wr_ok && (state_reg[fill_ptr_reg] == FREE)) state_reg[fill_ptr_reg] <= FILLING;
      if (commit_ok) begin
        state_reg[fill_ptr_reg] <= UNPACKING;
        fill_ptr_reg            <= fill_ptr_reg + 1'b1;
        ubank_reg               <= fill_ptr_reg;
        step_reg                <= '0;
      end
      if (ustate_reg == RUN) step_reg <= step_reg + 1'b1;
      if (last_step) state_reg[ubank_reg] <= READY;
      if (rel_ok) begin
        state_reg[rd_ptr_reg] <= FREE;
        rd_ptr_reg            <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      man_rd_reg   <= '0;
      al_rd_reg    <= '0;
      lane_reg     <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_ok;
      if (rd_ok) begin
        man_rd_reg <= man_mem[rd_ptr_reg][rd_addr];
        al_rd_reg  <= al_mem[rd_ptr_reg][STEP_W'(rd_addr / UNPACK_LANES)];
        lane_reg   <= LANE_W'(rd_addr % UNPACK_LANES);
      end
    end
  end

  assign exp_sel     = AL_BIT_W'(32'(lane_reg) * EXP_WIDTH);
  assign exp_rd_data = al_rd_reg[exp_sel +: EXP_WIDTH];
  assign man_rd_data = man_rd_reg;
  assign rd_valid    = rd_valid_reg;

endmodule

// File: rtl/dispatcher_bram_pp.sv
// Ping-pong staging memory top: write decode to the per-side banks and the shared error pulse.
module dispatcher_bram_pp
  import dispatcher_bram_pkg::*;
#(
  parameter int NUM_SIDES        = 2,
  parameter int NUM_BANKS        = 2,
  parameter int MAN_WIDTH        = DEF_MAN_WIDTH,
  parameter int EXP_WIDTH        = DEF_EXP_WIDTH,
  parameter int NUM_GROUPS       = DEF_NUM_GROUPS,
  parameter int UNPACK_LANES     = 4,
  parameter int EXP_PER_LINE     = MAN_WIDTH / EXP_WIDTH,
  parameter int EXP_PACKED_DEPTH = NUM_GROUPS / EXP_PER_LINE,
  parameter int WR_ADDR_WIDTH    = $clog2(EXP_PACKED_DEPTH + NUM_GROUPS),
  parameter int RD_ADDR_WIDTH    = $clog2(NUM_GROUPS),
  localparam int SIDE_W          = clog2_min1(NUM_SIDES)
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_wr_en,
  input  logic [SIDE_W-1:0]                  i_wr_side,
  input  logic [WR_ADDR_WIDTH-1:0]           i_wr_addr,
  input  logic [MAN_WIDTH-1:0]               i_wr_data,
  input  logic                               i_commit,
  output logic [NUM_SIDES-1:0]               o_wr_ready,
  input  logic [NUM_SIDES-1:0]               i_rd_en,
  input  logic [NUM_SIDES*RD_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_SIDES*MAN_WIDTH-1:0]     o_man_rd_data,
  output logic [NUM_SIDES*EXP_WIDTH-1:0]     o_exp_rd_data,
  output logic [NUM_SIDES-1:0]               o_rd_valid,
  output logic [NUM_SIDES-1:0]               o_bank_ready,
  input  logic [NUM_SIDES-1:0]               i_release,
  output logic                               o_err
);
  logic                 addr_ok, err_reg;
  logic [NUM_SIDES-1:0] side_sel, side_reject;

  assign addr_ok = 32'(i_wr_addr) < 32'(EXP_PACKED_DEPTH + NUM_GROUPS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SIDES; gi++) begin : g_side
      assign side_sel[gi] = (i_wr_side == SIDE_W'(gi));
      dispatcher_bram_side #(
        .NUM_BANKS        (NUM_BANKS),
        .MAN_WIDTH        (MAN_WIDTH),
        .EXP_WIDTH        (EXP_WIDTH),
        .NUM_GROUPS       (NUM_GROUPS),
        .UNPACK_LANES     (UNPACK_LANES),
        .EXP_PER_LINE     (EXP_PER_LINE),
        .EXP_PACKED_DEPTH (EXP_PACKED_DEPTH),
        .WR_ADDR_WIDTH    (WR_ADDR_WIDTH),
        .RD_ADDR_WIDTH    (RD_ADDR_WIDTH)
      ) u_side (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .wr_en       (i_wr_en && addr_ok && side_sel[gi]),
        .wr_addr     (i_wr_addr),
        .wr_data     (i_wr_data),
        .commit      (i_commit && side_sel[gi]),
        .wr_ready    (o_wr_ready[gi]),
        .rd_en       (i_rd_en[gi]),
        .rd_addr     (i_rd_addr[gi*RD_ADDR_WIDTH +: RD_ADDR_WIDTH]),
        .man_rd_data (o_man_rd_data[gi*MAN_WIDTH +: MAN_WIDTH]),
        .exp_rd_data (o_exp_rd_data[gi*EXP_WIDTH +: EXP_WIDTH]),
        .rd_valid    (o_rd_valid[gi]),
        .bank_ready  (o_bank_ready[gi]),
        .rel         (i_release[gi]),
        .reject      (side_reject[gi])
      );
    end
  endgenerate

  // An out-of-range write is rejected here; side-level rejections are ORed in.
  always_ff @(posedge i_clk) begin
    if (i_reset) err_reg <= 1'b0;
    else         err_reg <= (|side_reject) || (i_wr_en && !addr_ok);
  end

  assign o_err = err_reg;

endmodule

// File: tb/tb_dispatcher_bram_pp.sv
// Scoreboard bench for dispatcher_bram_pp: bank-level reference model plus read-data monitor.
module tb_dispatcher_bram_pp;
  localparam int NS = 2, NB = 2, MW = 256, EW = 8, NG = 512;
  localparam int EPL = 32, EPD = 16, WAW = 10, RAW = 9;
  localparam int UNPACK_CYCLES = 128;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               wr_en = 1'b0;
  logic [0:0]         wr_side = '0;
  logic [WAW-1:0]     wr_addr = '0;
  logic [MW-1:0]      wr_data = '0;
  logic               commit = 1'b0;
  logic [NS-1:0]      rd_en = '0;
  logic [NS*RAW-1:0]  rd_addr = '0;
  logic [NS-1:0]      rel = '0;
  logic [NS-1:0]      wr_ready, rd_valid, bank_ready;
  logic [NS*MW-1:0]   man_rd;
  logic [NS*EW-1:0]   exp_rd;
  logic               err;

  always #5 clk = ~clk;

  dispatcher_bram_pp dut (
    .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_side(wr_side), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_commit(commit), .o_wr_ready(wr_ready), .i_rd_en(rd_en),
    .i_rd_addr(rd_addr), .o_man_rd_data(man_rd), .o_exp_rd_data(exp_rd), .o_rd_valid(rd_valid),
    .o_bank_ready(bank_ready), .i_release(rel), .o_err(err)
  );

  // Reference model: bank contents, bank status (0 free,1 filling,2 unpacking,3 ready),
  // and a per-side countdown until the unpacking bank becomes readable.
  logic [MW-1:0] pk_m  [NS][NB][EPD];
  logic [MW-1:0] man_m [NS][NB][NG];
  int bst [NS][NB];
  int ucnt [NS], ub [NS], fp [NS], rp [NS];
  logic [MW-1:0] last_man [NS];
  logic [EW-1:0] last_exp [NS];

  typedef struct packed {
    logic [1:0]    side;
    logic [MW-1:0] man;
    logic [EW-1:0] exp;
  } rd_item_t;
  rd_item_t sbq[$];

  int total = 0;
  int bad = 0;

  function automatic logic [MW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [EW-1:0] exp_m(int s, int b, int g);
    logic [MW-1:0] line;
    line = pk_m[s][b][g / EPL];
    return line[EW*(g % EPL) +: EW];
  endfunction

  function automatic logic wr_ready_m(int s);
    return (bst[s][fp[s]] <= 1) && (ucnt[s] == 0);
  endfunction

  task automatic chk(string name, logic [MW-1:0] act, logic [MW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < NB; b++) bst[s][b] = 0;
      ucnt[s] = 0; ub[s] = 0; fp[s] = 0; rp[s] = 0;
      last_man[s] = '0; last_exp[s] = '0;
    end
  endtask

  // One clock: predict from pre-edge model, advance the model, then check status outputs.
  task automatic tick();
    logic [NS-1:0] wrr, br, rd_acc;
    logic err_e;
    int ws, g;
    ws = int'(wr_side);
    for (int s = 0; s < NS; s++) begin
      wrr[s] = wr_ready_m(s);
      br[s]  = (bst[s][rp[s]] == 3);
    end
    err_e = 1'b0;
    if (wr_en && ((int'(wr_addr) >= EPD + NG) || !wrr[ws])) err_e = 1'b1;
    if (commit && !wrr[ws]) err_e = 1'b1;
    rd_acc = '0;
    for (int s = 0; s < NS; s++) begin
      if ((rd_en[s] || rel[s]) && !br[s]) err_e = 1'b1;
      if (rd_en[s] && br[s] && !rst) begin
        rd_item_t it;
        g = int'(rd_addr[s*RAW +: RAW]);
        it.side = 2'(s);
        it.man  = man_m[s][rp[s]][g];
        it.exp  = exp_m(s, rp[s], g);
        sbq.push_back(it);
        last_man[s] = it.man;
        last_exp[s] = it.exp;
        rd_acc[s] = 1'b1;
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
      err_e = 1'b0;
    end else begin
      for (int s = 0; s < NS; s++)
        if (ucnt[s] > 0) begin
          ucnt[s]--;
          if (ucnt[s] == 0) bst[s][ub[s]] = 3;
        end
      if (wr_en && (int'(wr_addr) < EPD + NG) && wrr[ws]) begin
        if (int'(wr_addr) < EPD) pk_m[ws][fp[ws]][int'(wr_addr)] = wr_data;
        else man_m[ws][fp[ws]][int'(wr_addr) - EPD] = wr_data;
        if (bst[ws][fp[ws]] == 0) bst[ws][fp[ws]] = 1;
      end
      if (commit && wrr[ws]) begin
        bst[ws][fp[ws]] = 2;
        ub[ws] = fp[ws];
        ucnt[ws] = UNPACK_CYCLES;
        fp[ws] = (fp[ws] + 1) % NB;
      end
      for (int s = 0; s < NS; s++)
        if (rel[s] && br[s]) begin
          bst[s][rp[s]] = 0;
          rp[s] = (rp[s] + 1) % NB;
        end
    end
    #1;
    chk("err", MW'(err), MW'(err_e));
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("wr_ready%0d", s), MW'(wr_ready[s]), MW'(wr_ready_m(s)));
      chk($sformatf("bank_ready%0d", s), MW'(bank_ready[s]), MW'(bst[s][rp[s]] == 3));
      chk($sformatf("rd_valid%0d", s), MW'(rd_valid[s]), MW'(rd_acc[s]));
      if (rd_en[s] && !rd_acc[s] && !rst) begin
        chk($sformatf("man_hold%0d", s), man_rd[s*MW +: MW], last_man[s]);
        chk($sformatf("exp_hold%0d", s), MW'(exp_rd[s*EW +: EW]), MW'(last_exp[s]));
      end
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (rd_valid[s] === 1'b1) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected side=%0d actual=valid required=none", s);
        end else begin
          rd_item_t e;
          e = sbq.pop_front();
          if (int'(e.side) != s || man_rd[s*MW +: MW] !== e.man || exp_rd[s*EW +: EW] !== e.exp) begin
            bad++;
            $display("FAIL rd_data side=%0d actual exp=%0h man=%0h required side=%0d exp=%0h man=%0h",
                     s, exp_rd[s*EW +: EW], man_rd[s*MW +: MW], e.side, e.exp, e.man);
          end
        end
      end
    end
  end

  task automatic idle();
    wr_en = 1'b0; commit = 1'b0; rd_en = '0; rel = '0;
  endtask

  task automatic do_write(int s, int a, logic [MW-1:0] d);
    wr_en = 1'b1; wr_side = 1'(s); wr_addr = WAW'(a); wr_data = d;
    tick(); idle();
  endtask

  task automatic do_commit(int s);
    commit = 1'b1; wr_side = 1'(s);
    tick(); idle();
  endtask

  task automatic do_read(int s, int g);
    rd_en[s] = 1'b1; rd_addr[s*RAW +: RAW] = RAW'(g);
    tick(); idle();
  endtask

  task automatic do_release(int s);
    rel[s] = 1'b1;
    tick(); idle();
  endtask

  task automatic fill_full(int s);
    for (int a = 0; a < EPD + NG; a++) do_write(s, a, rnd_line());
  endtask

  task automatic wait_ready(int s);
    int n = 0;
    while (bank_ready[s] !== 1'b1 && n < 300) begin tick(); n++; end
    chk("wait_ready_timeout", MW'(bank_ready[s]), MW'(1));
  endtask

  initial begin
    logic [MW-1:0] line;
    int k;
    model_reset();
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < NB; b++) begin
        for (int a = 0; a < EPD; a++) pk_m[s][b][a] = '0;
        for (int a = 0; a < NG; a++) man_m[s][b][a] = '0;
      end

    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("reset_man", man_rd, '0);
    chk("reset_exp", MW'(exp_rd), '0);

    // Directed fill, commit-to-ready latency and first read
    fill_full(0);
    line = rnd_line(); line[47:40] = 8'h7A;
    do_write(0, 0, line);
    do_write(0, EPD + 5, {32{8'hA5}});
    do_commit(0);
    k = 1;
    while (bank_ready[0] !== 1'b1 && k < 300) begin tick(); k++; end
    chk("commit_to_ready", MW'(k), MW'(129));
    do_read(0, 5);
    chk("exp_7A", MW'(exp_rd[7:0]), MW'(8'h7A));
    chk("man_A5", man_rd[MW-1:0], {32{8'hA5}});

    // Ping-pong: fill bank 1 while reading bank 0
    for (int a = 0; a < EPD + NG; a++) begin
      line = rnd_line();
      if (a == 15) line[255:248] = 8'hC3;
      wr_en = 1'b1; wr_side = 1'b0; wr_addr = WAW'(a); wr_data = line;
      rd_en[0] = 1'b1; rd_addr[RAW-1:0] = RAW'($urandom_range(0, NG - 1));
      tick(); idle();
    end
    do_commit(0);
    do_release(0);
    wait_ready(0);
    do_read(0, 511);
    chk("exp_C3", MW'(exp_rd[7:0]), MW'(8'hC3));

    // Full side 1
    fill_full(1); do_commit(1); wait_ready(1);
    fill_full(1); do_commit(1);
    for (int i = 0; i < 135; i++) tick();
    chk("full_wr_ready1", MW'(wr_ready[1]), MW'(0));
    do_write(1, 20, rnd_line());
    do_commit(1);
    do_read(1, 4);
    do_release(1);
    chk("after_release_wr_ready1", MW'(wr_ready[1]), MW'(1));

    // Error cases on side 0
    do_write(0, 528, rnd_line());
    do_release(0);
    do_read(0, 3);
    do_release(0);

    // Simultaneous release + commit (with a line-0 write) on side 0, dual-side read
    for (int i = 0; i < 40; i++) do_write(0, $urandom_range(0, EPD + NG - 1), rnd_line());
    do_commit(0); wait_ready(0);
    for (int i = 0; i < 5; i++) do_write(0, $urandom_range(1, EPD + NG - 1), rnd_line());
    wr_en = 1'b1; wr_side = 1'b0; wr_addr = '0; wr_data = rnd_line();
    commit = 1'b1; rel = 2'b01; rd_en = 2'b11; rd_addr = '0;
    tick(); idle();
    chk("simul_bank_ready0", MW'(bank_ready[0]), MW'(0));
    wait_ready(0);
    for (int g = 0; g < 4; g++) do_read(0, g);

    // Randomised traffic
    for (int it = 0; it < 2500; it++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_side = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 40) == 0) ? WAW'(528 + $urandom_range(0, 495))
                                             : WAW'($urandom_range(0, EPD + NG - 1));
      wr_data = rnd_line();
      commit  = ($urandom_range(0, 60) == 0);
      rd_en   = 2'($urandom_range(0, 3));
      rd_addr = {RAW'($urandom_range(0, NG - 1)), RAW'($urandom_range(0, NG - 1))};
      rel     = {($urandom_range(0, 80) == 0), ($urandom_range(0, 80) == 0)};
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Reset in the middle of an unpack, then a clean refill
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) do_write(0, $urandom_range(0, EPD + NG - 1), rnd_line());
    do_commit(0);
    for (int i = 0; i < 60; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_bank_ready", MW'(bank_ready), MW'(0));
    chk("rst_mid_wr_ready", MW'(wr_ready), MW'(2'b11));
    for (int i = 0; i < 8; i++) do_write(0, $urandom_range(0, EPD + NG - 1), rnd_line());
    do_commit(0); wait_ready(0);
    for (int i = 0; i < 6; i++) do_read(0, $urandom_range(0, NG - 1));
    tick(); tick();
    chk("scoreboard_drained", MW'(sbq.size()), MW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
